tqvp_stevej_wdt_kicker: RTL and testbench

TQVP_STEVEJ_WDT_KICKER -- requirements
Module: tqvp_stevej_wdt_kicker

---
 rtl/tqvp_stevej_wdt_pkg.sv | 36 +++
 rtl/tqvp_stevej_kick_timer.sv | 73 +++++++
 rtl/tqvp_stevej_wdt_kicker.sv | 108 ++++++++++
 tb/tb_tqvp_stevej_wdt_kicker.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_stevej_wdt_pkg.sv
// Shared constants for the watchdog kicker: register map, CTRL/STATUS bit
// positions, timer FSM encoding and the write-width helper.
package tqvp_stevej_wdt_pkg;

  localparam logic [5:0] ADDR_CTRL       = 6'h0;
  localparam logic [5:0] ADDR_PERIOD     = 6'h1;
  localparam logic [5:0] ADDR_WIDTH      = 6'h2;
  localparam logic [5:0] ADDR_KICK       = 6'h3;
  localparam logic [5:0] ADDR_STATUS     = 6'h4;
  localparam logic [5:0] ADDR_KICK_COUNT = 6'h5;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_AUTO     = 1;
  localparam int CTRL_INVERT   = 2;
  localparam int CTRL_FAULT_IE = 3;

  localparam int STATUS_BUSY    = 0;
  localparam int STATUS_FAULT   = 1;
  localparam int STATUS_OVERRUN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_PULSE = 2'd2
  } timer_state_t;

  // 00 = byte, 01 = half-word, 10 = word; bytes outside the access are dropped
  function automatic logic [31:0] write_mask(input logic [1:0] write_n);
    case (write_n)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_stevej_kick_timer.sv
// Period/pulse timer: one counter times the gap between kicks in COUNT and
// the pulse length in PULSE, both compared live against the registers.
module tqvp_stevej_kick_timer
  import tqvp_stevej_wdt_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         auto_mode,
  input  logic         kick_req,
  input  logic [31:0]  period,
  input  logic [7:0]   width,
  output timer_state_t state,
  output logic         kick_done
);

  logic [31:0] counter;
  logic [32:0] count_next;
  logic [32:0] period_min;
  logic [32:0] width_min;

  // A zero PERIOD or WIDTH behaves as one cycle
  always_comb begin
    count_next = {1'b0, counter} + 33'd1;
    period_min = (period == 32'd0) ? 33'd1 : {1'b0, period};
    width_min  = (width == 8'd0) ? 33'd1 : {25'd0, width};
  end

  assign kick_done = (state == ST_PULSE) && enable && (count_next >= width_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      counter <= 32'd0;
    end else if (!enable) begin
      state   <= ST_IDLE;
      counter <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state   <= ST_COUNT;
          counter <= 32'd0;
        end
        ST_COUNT: begin
          if (auto_mode) begin
            if (count_next >= period_min) begin
              state   <= ST_PULSE;
              counter <= 32'd0;
            end else begin
              counter <= count_next[31:0];
            end
          end else if (kick_req) begin
            state   <= ST_PULSE;
            counter <= 32'd0;
          end
        end
        ST_PULSE: begin
          if (count_next >= width_min) begin
            state   <= ST_COUNT;
            counter <= 32'd0;
          end else begin
            counter <= count_next[31:0];
          end
        end
        default: begin
          state   <= ST_IDLE;
          counter <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tqvp_stevej_wdt_kicker.sv
// TinyQV peripheral that kicks an external watchdog on a programmable period
// or on demand, and latches the watchdog's FAULT line as an interrupt.
module tqvp_stevej_wdt_kicker
  import tqvp_stevej_wdt_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  logic [3:0]   ctrl;
  logic [3:0]   ctrl_eff;
  logic [31:0]  period;
  logic [7:0]   width;
  logic [31:0]  kick_count;
  logic         fault_latched;
  logic         overrun;
  logic         fault_prev;
  logic         wr_en;
  logic [31:0]  wdata;
  logic         wr_kick;
  logic         wr_status;
  logic         fault_set;
  logic         overrun_set;
  logic         kick_level;
  logic         kick_done;
  timer_state_t state;
  logic         unused_ok;

  assign wr_en     = (data_write_n != 2'b11);
  assign wdata     = data_in & write_mask(data_write_n);
  assign wr_kick   = wr_en && (address == ADDR_KICK);
  assign wr_status = wr_en && (address == ADDR_STATUS);

  // The timer sees the CTRL value being written so enable/disable act next cycle
  assign ctrl_eff = (wr_en && (address == ADDR_CTRL)) ? wdata[3:0] : ctrl;

  tqvp_stevej_kick_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (ctrl_eff[CTRL_ENABLE]),
    .auto_mode (ctrl_eff[CTRL_AUTO]),
    .kick_req  (wr_kick),
    .period    (period),
    .width     (width),
    .state     (state),
    .kick_done (kick_done)
  );

  assign fault_set   = ui_in[1] && !fault_prev;
  assign overrun_set = wr_kick && ((state == ST_PULSE) ||
                                   ((state == ST_COUNT) && ctrl_eff[CTRL_AUTO]));

  // Set events win over a simultaneous write-one-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl          <= 4'd0;
      period        <= 32'd0;
      width         <= 8'd0;
      kick_count    <= 32'd0;
      fault_latched <= 1'b0;
      overrun       <= 1'b0;
      fault_prev    <= 1'b0;
    end else begin
      fault_prev <= ui_in[1];
      ctrl       <= ctrl_eff;
      if (wr_en && (address == ADDR_PERIOD)) period <= wdata;
      if (wr_en && (address == ADDR_WIDTH))  width  <= wdata[7:0];
      if (kick_done) kick_count <= kick_count + 32'd1;
      fault_latched <= fault_set ||
                       (fault_latched && !(wr_status && wdata[STATUS_FAULT]));
      overrun       <= overrun_set ||
                       (overrun && !(wr_status && wdata[STATUS_OVERRUN]));
    end
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_CTRL:       data_out = {28'd0, ctrl};
      ADDR_PERIOD:     data_out = period;
      ADDR_WIDTH:      data_out = {24'd0, width};
      ADDR_STATUS: begin
        data_out[STATUS_BUSY]    = (state == ST_PULSE);
        data_out[STATUS_FAULT]   = fault_latched;
        data_out[STATUS_OVERRUN] = overrun;
      end
      ADDR_KICK_COUNT: data_out = kick_count;
      default:         data_out = 32'd0;
    endcase
  end

  assign kick_level     = (state == ST_PULSE) ^ ctrl[CTRL_INVERT];
  assign uo_out         = {4'd0, ctrl[CTRL_ENABLE], fault_latched, kick_level, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = fault_latched && ctrl[CTRL_FAULT_IE];

  assign unused_ok = &{1'b0, data_read_n, ui_in[7:2], ui_in[0]};

endmodule

// File: tb/tb_tqvp_stevej_wdt_kicker.sv
// Scoreboard bench for the watchdog kicker: directed scenarios plus random
// bus traffic, checked against a cycle-level behavioural model.
module tb_tqvp_stevej_wdt_kicker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  always #5 clk = ~clk;

  tqvp_stevej_wdt_kicker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  typedef struct {
    logic [7:0]  uo;
    logic        irq;
    bit          rd;
    logic [31:0] data;
    bit          dir_on;
    logic [31:0] dir_mask;
    logic [31:0] dir_val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;
  bit    fault_level;

  // Behavioural model: registers plus "active / pulsing" flags and elapsed times
  bit          m_en, m_auto, m_inv, m_fie;
  bit          m_active, m_in_pulse, m_fault, m_over, m_fprev;
  logic [31:0] m_period, m_kcount;
  logic [7:0]  m_width;
  longint      m_elapsed, m_age;

  task automatic model_reset();
    {m_en, m_auto, m_inv, m_fie} = 4'b0;
    {m_active, m_in_pulse, m_fault, m_over, m_fprev} = 5'b0;
    m_period = 32'd0; m_kcount = 32'd0; m_width = 8'd0;
    m_elapsed = 0; m_age = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [5:0] a);
    case (a)
      6'd0:    return {28'd0, m_fie, m_inv, m_auto, m_en};
      6'd1:    return m_period;
      6'd2:    return {24'd0, m_width};
      6'd4:    return {29'd0, m_over, m_fault, m_in_pulse};
      6'd5:    return m_kcount;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [5:0] a, input logic [1:0] wn,
                            input logic [31:0] d, input bit f);
    bit wr, kick_wr, en_n, auto_n, fset, oset;
    logic [31:0] md;
    longint plim, wlim;
    wr = (wn != 2'b11);
    md = (wn == 2'b00) ? (d & 32'hFF) : (wn == 2'b01) ? (d & 32'hFFFF) : d;
    en_n   = (wr && a == 6'd0) ? md[0] : m_en;
    auto_n = (wr && a == 6'd0) ? md[1] : m_auto;
    kick_wr = wr && (a == 6'd3);
    plim = (m_period == 32'd0) ? 64'd1 : {32'd0, m_period};
    wlim = (m_width == 8'd0) ? 64'd1 : {56'd0, m_width};
    fset = f && !m_fprev;
    oset = kick_wr && m_active && (m_in_pulse || auto_n);
    if (!en_n) begin
      m_active = 0; m_in_pulse = 0; m_elapsed = 0;
    end else if (!m_active) begin
      m_active = 1; m_elapsed = 0;
    end else if (m_in_pulse) begin
      if (m_age + 1 >= wlim) begin
        m_in_pulse = 0; m_elapsed = 0; m_kcount = m_kcount + 1;
      end else m_age = m_age + 1;
    end else if (auto_n) begin
      if (m_elapsed + 1 >= plim) begin
        m_in_pulse = 1; m_age = 0;
      end else m_elapsed = m_elapsed + 1;
    end else if (kick_wr) begin
      m_in_pulse = 1; m_age = 0;
    end
    if (wr && a == 6'd0) {m_fie, m_inv, m_auto, m_en} = md[3:0];
    if (wr && a == 6'd1) m_period = md;
    if (wr && a == 6'd2) m_width = md[7:0];
    m_fault = fset || (m_fault && !(wr && a == 6'd4 && md[1]));
    m_over  = oset || (m_over && !(wr && a == 6'd4 && md[2]));
    m_fprev = f;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, expv);
    end
  endtask

  // One bus cycle: push the expected response, drive, then advance the model
  task automatic applyStimulus(input logic [5:0] a, input logic [1:0] wn,
                               input logic [31:0] d, input bit rd, input bit f,
                               input bit dir_on, input logic [31:0] dmask,
                               input logic [31:0] dval, input string nm);
    exp_t e;
    e.uo = {4'd0, m_en, m_fault, m_in_pulse ^ m_inv, 1'b0};
    e.irq = m_fault && m_fie;
    e.rd = rd;
    e.data = model_read(a);
    e.dir_on = dir_on; e.dir_mask = dmask; e.dir_val = dval;
    exp_q.push_back(e);
    name_q.push_back(nm);
    address = a; data_in = d; data_write_n = wn;
    data_read_n = rd ? 2'b00 : 2'b11;
    ui_in = 8'($urandom());
    ui_in[1] = f;
    @(posedge clk);
    if (rst_n) model_step(a, wn, d, f);
    else model_reset();
    #1;
  endtask

  task automatic tick(input string nm);
    applyStimulus(6'd0, 2'b11, 32'($urandom()), 1'b0, fault_level, 1'b0, 32'd0, 32'd0, nm);
  endtask

  task automatic kickChk(input bit lvl, input string nm);
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, fault_level, 1'b1, 32'h2, {30'd0, lvl, 1'b0}, nm);
  endtask

  task automatic writeReg(input logic [5:0] a, input logic [31:0] d, input string nm);
    applyStimulus(a, 2'b10, d, 1'b0, fault_level, 1'b0, 32'd0, 32'd0, nm);
  endtask

  task automatic writeKickChk(input logic [5:0] a, input logic [31:0] d,
                              input bit lvl, input string nm);
    applyStimulus(a, 2'b10, d, 1'b0, fault_level, 1'b1, 32'h2, {30'd0, lvl, 1'b0}, nm);
  endtask

  task automatic readChk(input logic [5:0] a, input logic [31:0] v, input string nm);
    applyStimulus(a, 2'b11, 32'd0, 1'b1, fault_level, 1'b1, 32'hFFFF_FFFF, v, nm);
  endtask

  // Pull reset between clock edges while a pulse is running
  task automatic asyncResetMidPulse();
    address = 6'd0; data_write_n = 2'b11; data_read_n = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset/uo_out", {24'd0, uo_out}, 32'd0);
    checkOutput("async_reset/irq", {31'd0, user_interrupt}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
  endtask

  exp_t        mon_e;
  string       mon_n;
  logic [31:0] mon_obs;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checkOutput({mon_n, "/uo_out"}, {24'd0, uo_out}, {24'd0, mon_e.uo});
      checkOutput({mon_n, "/irq"}, {31'd0, user_interrupt}, {31'd0, mon_e.irq});
      checkOutput({mon_n, "/ready"}, {31'd0, data_ready}, 32'd1);
      if (mon_e.rd) checkOutput({mon_n, "/data_out"}, data_out, mon_e.data);
      if (mon_e.dir_on) begin
        mon_obs = mon_e.rd ? data_out : {23'd0, user_interrupt, uo_out};
        checkOutput({mon_n, "/directed"}, mon_obs & mon_e.dir_mask,
                    mon_e.dir_val & mon_e.dir_mask);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [5:0]  a;
    logic [1:0]  wn;
    logic [31:0] d;
    bit          rd;

    rst_n = 1'b0; ui_in = 8'd0; address = 6'd0; data_in = 32'd0;
    data_write_n = 2'b11; data_read_n = 2'b11; fault_level = 1'b0;
    model_reset();
    @(posedge clk); #1;

    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1FF, 32'd0, "reset_outputs");
    readChk(6'd0, 32'd0, "reset_ctrl");
    readChk(6'd5, 32'd0, "reset_kick_count");
    rst_n = 1'b1;
    tick("post_reset");

    // Auto mode, PERIOD=10, WIDTH=3
    writeReg(6'd1, 32'd10, "s1_period");
    writeReg(6'd2, 32'd3, "s1_width");
    writeKickChk(6'd0, 32'h3, 1'b0, "s1_enable");
    for (int c = 1; c <= 26; c++)
      kickChk((c >= 11 && c <= 13) || (c >= 24 && c <= 26), $sformatf("s1_cycle%0d", c));
    readChk(6'd5, 32'd2, "s1_kick_count");
    writeReg(6'd0, 32'h0, "s1_disable");

    // Manual kick, then a second kick during the pulse
    writeReg(6'd2, 32'd0, "s2_width");
    writeReg(6'd0, 32'h1, "s2_enable");
    tick("s2_wait");
    writeKickChk(6'd3, 32'd1, 1'b0, "s2_kick");
    writeKickChk(6'd3, 32'd1, 1'b1, "s2_pulse_kick");
    kickChk(1'b0, "s2_no_second_pulse");
    kickChk(1'b0, "s2_still_low");
    readChk(6'd4, 32'h4, "s2_status_overrun");
    readChk(6'd5, 32'd3, "s2_kick_count");
    writeReg(6'd4, 32'h4, "s2_clear_overrun");
    readChk(6'd4, 32'h0, "s2_status_clear");
    writeReg(6'd0, 32'h0, "s2_disable");

    // Abort a 5-cycle pulse on its second cycle
    writeReg(6'd2, 32'd5, "s3_width");
    writeReg(6'd1, 32'd2, "s3_period");
    writeKickChk(6'd0, 32'h3, 1'b0, "s3_enable");
    kickChk(1'b0, "s3_cycle1");
    kickChk(1'b0, "s3_cycle2");
    kickChk(1'b1, "s3_pulse1");
    writeKickChk(6'd0, 32'h0, 1'b1, "s3_pulse2_disable");
    kickChk(1'b0, "s3_aborted");
    readChk(6'd5, 32'd3, "s3_kick_count");

    // Fault latch, interrupt and write-one-to-clear with FAULT held high
    writeReg(6'd0, 32'h9, "s4_ctrl");
    fault_level = 1'b1;
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h000, "s4_rise");
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h104, "s4_latched");
    readChk(6'd4, 32'h2, "s4_status");
    writeReg(6'd4, 32'h2, "s4_w1c");
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h000, "s4_cleared");
    readChk(6'd4, 32'h0, "s4_status_clear");
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b1, 1'b1, 32'h104, 32'h000, "s4_held");
    fault_level = 1'b0;
    writeReg(6'd0, 32'h0, "s4_disable");

    // Inverted kick output
    writeReg(6'd0, 32'h6, "s5_idle_invert");
    kickChk(1'b1, "s5_idle_level");
    writeReg(6'd1, 32'd4, "s5_period");
    writeReg(6'd2, 32'd2, "s5_width");
    writeKickChk(6'd0, 32'h7, 1'b1, "s5_enable");
    for (int c = 1; c <= 8; c++)
      kickChk(!(c == 5 || c == 6), $sformatf("s5_cycle%0d", c));
    writeReg(6'd0, 32'h0, "s5_disable");

    // Asynchronous reset in the middle of a pulse
    writeReg(6'd1, 32'd3, "s6_period");
    writeReg(6'd2, 32'd6, "s6_width");
    writeKickChk(6'd0, 32'h3, 1'b0, "s6_enable");
    for (int c = 1; c <= 3; c++) kickChk(1'b0, $sformatf("s6_cycle%0d", c));
    kickChk(1'b1, "s6_pulse1");
    writeKickChk(6'd3, 32'd1, 1'b1, "s6_pulse2_overrun");
    asyncResetMidPulse();
    applyStimulus(6'd0, 2'b11, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1FF, 32'd0, "s6_rst_outputs");
    readChk(6'd0, 32'd0, "s6_rst_ctrl");
    readChk(6'd1, 32'd0, "s6_rst_period");
    readChk(6'd2, 32'd0, "s6_rst_width");
    readChk(6'd4, 32'd0, "s6_rst_status");
    readChk(6'd5, 32'd0, "s6_rst_kick_count");
    rst_n = 1'b1;
    tick("s6_release");
    readChk(6'd4, 32'd0, "s6_after_release");

    // Random bus traffic against the model
    for (int i = 0; i < 1500; i++) begin
      a = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = 6'($urandom_range(0, 63));
      wn = ($urandom_range(0, 99) < 35) ? 2'($urandom_range(0, 2)) : 2'b11;
      case (a)
        6'd0: begin
          d = $urandom() & 32'hFFFF_FFF0;
          d[0] = ($urandom_range(0, 99) < 85);
          d[3:1] = 3'($urandom());
        end
        6'd1: d = 32'($urandom_range(0, 12)) |
                  ((wn == 2'b00) ? ($urandom() & 32'hFFFF_FF00) : 32'd0);
        6'd2: d = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 4));
        default: d = $urandom();
      endcase
      rd = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) fault_level = ~fault_level;
      applyStimulus(a, wn, d, rd, fault_level, 1'b0, 32'd0, 32'd0, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
